// File: rtl/aurora_hls_rx_level_if.sv
// Aurora RX FIFO occupancy-tracker bus: beat/handshake inputs plus the level,
// flag and statistics outputs.
interface aurora_hls_rx_level_if #(
    parameter int LVL_W = 10
);
    logic             wr_beat;
    logic             rd_valid;
    logic             rd_ready;
    logic             stats_clear;
    logic             fifo_rx_prog_full;
    logic             fifo_rx_prog_empty;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] peak_level;
    logic [31:0]      overflow_count;
    logic             underflow_sticky;

    modport master (
        output wr_beat, rd_valid, rd_ready, stats_clear,
        input  fifo_rx_prog_full, fifo_rx_prog_empty, level, peak_level,
               overflow_count, underflow_sticky
    );

    modport slave (
        input  wr_beat, rd_valid, rd_ready, stats_clear,
        output fifo_rx_prog_full, fifo_rx_prog_empty, level, peak_level,
               overflow_count, underflow_sticky
    );
endinterface

// File: rtl/aurora_hls_rx_level.sv
// RX FIFO occupancy tracker with hysteresis prog_full/prog_empty flags feeding
// the NFC XON/XOFF generator, plus overflow/underflow/peak statistics.
module aurora_hls_rx_level #(
    parameter int DEPTH        = 512,
    parameter int FULL_THRESH  = 384,
    parameter int EMPTY_THRESH = 128,
    parameter int HYST         = 32,
    parameter int LVL_W        = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aurora_hls_rx_level_if.slave bus
);
    localparam logic [LVL_W-1:0] DEPTH_L    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] E_EXIT_L   = LVL_W'(EMPTY_THRESH + HYST);
    localparam logic [LVL_W-1:0] E_ENTER_L  = LVL_W'(EMPTY_THRESH);
    localparam logic [LVL_W-1:0] F_ENTER_L  = LVL_W'(FULL_THRESH);
    localparam logic [LVL_W-1:0] F_EXIT_L   = LVL_W'(FULL_THRESH - HYST);

    typedef enum logic [1:0] {
        Z_EMPTY,
        Z_MID,
        Z_FULL
    } zone_e;

    zone_e            zone_q, zone_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] peak_q, peak_d;
    logic [31:0]      overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             prog_full_q, prog_empty_q;
    logic             wr, rd;

    always_comb begin
        wr          = bus.wr_beat;
        rd          = bus.rd_valid && bus.rd_ready;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Simultaneous write and read is a pass-through and never flags over/underflow.
        if (wr && !rd) begin
            if (level_q == DEPTH_L) begin
                if (overflow_q != '1) overflow_d = overflow_q + 32'd1;
            end else begin
                level_d = level_q + LVL_W'(1);
            end
        end else if (rd && !wr) begin
            if (level_q == '0) underflow_d = 1'b1;
            else               level_d     = level_q - LVL_W'(1);
        end

        zone_d = zone_q;
        case (zone_q)
            Z_EMPTY: if (level_d > E_EXIT_L) zone_d = Z_MID;
            Z_MID: begin
                if (level_d <= E_ENTER_L)      zone_d = Z_EMPTY;
                else if (level_d >= F_ENTER_L) zone_d = Z_FULL;
            end
            Z_FULL:  if (level_d < F_EXIT_L) zone_d = Z_MID;
            default: zone_d = Z_EMPTY;
        endcase

        peak_d = (level_d > peak_q) ? level_d : peak_q;
        if (bus.stats_clear) begin
            overflow_d  = '0;
            underflow_d = 1'b0;
            peak_d      = level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zone_q       <= Z_EMPTY;
            level_q      <= '0;
            peak_q       <= '0;
            overflow_q   <= '0;
            underflow_q  <= 1'b0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else begin
            zone_q       <= zone_d;
            level_q      <= level_d;
            peak_q       <= peak_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            prog_full_q  <= (zone_d == Z_FULL);
            prog_empty_q <= (zone_d == Z_EMPTY);
        end
    end

    assign bus.level              = level_q;
    assign bus.peak_level         = peak_q;
    assign bus.overflow_count     = overflow_q;
    assign bus.underflow_sticky   = underflow_q;
    assign bus.fifo_rx_prog_full  = prog_full_q;
    assign bus.fifo_rx_prog_empty = prog_empty_q;
endmodule
